// File: rtl/execute_calc_mc_if.sv
// execute_calc_mc_if
//   Bundles the decode-side request, the flush line and the result/memory/branch
//   outputs of the execute stage.
//   Modports:
//     master : decode/control side (drives flush, in_*, samples results)
//     slave  : the execute stage itself
//   Parameters: XLEN (datapath width), MASK_W (byte-mask width, XLEN/8).
interface execute_calc_mc_if #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN/8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_alu_op;
    logic [3:0]        in_br_op;
    logic [1:0]        in_mem_op;
    logic [2:0]        in_funct3;
    logic              in_use_rs2;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic [XLEN-1:0]   in_imm;
    logic              out_valid;
    logic [XLEN-1:0]   out_alu_result;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
    logic              mem_write;
    logic              mem_read;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_mask;

    modport master (
        output flush, in_valid, in_alu_op, in_br_op, in_mem_op, in_funct3,
               in_use_rs2, in_pc, in_rs1_val, in_rs2_val, in_imm,
        input  in_ready, out_valid, out_alu_result, branch_taken, branch_target,
               mem_write, mem_read, mem_addr, mem_wdata, mem_mask
    );

    modport slave (
        input  flush, in_valid, in_alu_op, in_br_op, in_mem_op, in_funct3,
               in_use_rs2, in_pc, in_rs1_val, in_rs2_val, in_imm,
        output in_ready, out_valid, out_alu_result, branch_taken, branch_target,
               mem_write, mem_read, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/execute_calc_mc.sv
// execute_calc_mc
//   Execute stage: XLEN-wide ALU, branch resolution and memory-request
//   generation with a registered one-cycle result, plus an optional iterative
//   restoring unsigned divider (one quotient bit per cycle) that stalls decode
//   through in_ready while it runs.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : execute_calc_mc_if.slave (flush, in_* request, out_*/branch/mem results)
//   Build option:
//     EXECUTE_CALC_MC_DIV_EN defined   -> iterative DIV/REM with stall
//     EXECUTE_CALC_MC_DIV_EN undefined -> no divider, in_ready tied high,
//                                         DIV/REM return 0 in one cycle
module execute_calc_mc #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN/8
) (
    input  logic             clk,
    input  logic             reset,
    execute_calc_mc_if.slave bus
);
    // Alu_pkg / Br_pkg / Mem_pkg encodings
    localparam logic [4:0] ALU_NONE = 5'd0,  ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,
                           ALU_AND  = 5'd3,  ALU_OR   = 5'd4,  ALU_XOR  = 5'd5,
                           ALU_SLL  = 5'd6,  ALU_SRL  = 5'd7,  ALU_SRA  = 5'd8,
                           ALU_SLT  = 5'd9,  ALU_SLTU = 5'd10, ALU_PASS = 5'd11,
                           ALU_MUL  = 5'd12, ALU_MULH = 5'd13, ALU_DIV  = 5'd14,
                           ALU_REM  = 5'd15;
    localparam logic [3:0] BR_NONE = 4'd0, BR_EQ  = 4'd1, BR_NE   = 4'd2,
                           BR_LT   = 4'd3, BR_GE  = 4'd4, BR_LTU  = 4'd5,
                           BR_GEU  = 4'd6, BR_JAL = 4'd7, BR_JALR = 4'd8,
                           BR_JR   = 4'd9, BR_EQZ = 4'd10, BR_NEZ = 4'd11;
    localparam logic [1:0] MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2;
    localparam int SH_W = $clog2(XLEN);

    logic              w_in_ready;
    logic              w_accept;
    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;
    logic [SH_W-1:0]   w_shamt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_lt_s, w_lt_u, w_eq;
    logic [XLEN-1:0]   w_pc_imm, w_rs1_imm;
    logic              w_br_taken;
    logic [XLEN-1:0]   w_br_target;
    logic              w_mem_write, w_mem_read;
    logic [MASK_W-1:0] w_mem_mask;
    logic              w_div_start;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_result;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_br_taken;
    logic [XLEN-1:0]   r_br_target;
    logic              r_mem_write, r_mem_read;
    logic [XLEN-1:0]   r_mem_addr, r_mem_wdata;
    logic [MASK_W-1:0] r_mem_mask;

    assign w_accept = bus.in_valid && w_in_ready;

    // Address generation for loads/stores always uses the immediate.
    assign w_op_a = bus.in_rs1_val;
    assign w_op_b = (bus.in_alu_op == ALU_ADD && bus.in_mem_op != MEM_NONE) ? bus.in_imm :
                    (bus.in_use_rs2 || bus.in_br_op == BR_EQZ || bus.in_br_op == BR_NEZ)
                        ? bus.in_rs2_val : bus.in_imm;

    assign w_shamt = w_op_b[SH_W-1:0];
    assign w_prod  = {{XLEN{1'b0}}, w_op_a} * {{XLEN{1'b0}}, w_op_b};
    assign w_lt_s  = $signed(w_op_a) < $signed(w_op_b);
    assign w_lt_u  = w_op_a < w_op_b;
    assign w_eq    = w_op_a == w_op_b;

    always_comb begin
        w_alu_res = '0;
        case (bus.in_alu_op)
            ALU_ADD:  w_alu_res = w_op_a + w_op_b;
            ALU_SUB:  w_alu_res = w_op_a - w_op_b;
            ALU_AND:  w_alu_res = w_op_a & w_op_b;
            ALU_OR:   w_alu_res = w_op_a | w_op_b;
            ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            ALU_SLL:  w_alu_res = w_op_a << w_shamt;
            ALU_SRL:  w_alu_res = w_op_a >> w_shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_PASS: w_alu_res = w_op_b;
            ALU_MUL:  w_alu_res = w_prod[XLEN-1:0];
            ALU_MULH: w_alu_res = w_prod[2*XLEN-1:XLEN];
`ifdef EXECUTE_CALC_MC_DIV_EN
            // Only the divide-by-zero case finishes here; B!=0 goes to the divider.
            ALU_DIV:  w_alu_res = (w_op_b == '0) ? '1 : '0;
            ALU_REM:  w_alu_res = (w_op_b == '0) ? w_op_a : '0;
`endif
            default:  w_alu_res = '0;
        endcase
    end

    assign w_pc_imm  = bus.in_pc + bus.in_imm;
    assign w_rs1_imm = bus.in_rs1_val + bus.in_imm;

    always_comb begin
        w_br_taken  = 1'b0;
        w_br_target = w_pc_imm;
        case (bus.in_br_op)
            BR_EQ, BR_EQZ: w_br_taken = w_eq;
            BR_NE, BR_NEZ: w_br_taken = !w_eq;
            BR_LT:         w_br_taken = w_lt_s;
            BR_GE:         w_br_taken = !w_lt_s;
            BR_LTU:        w_br_taken = w_lt_u;
            BR_GEU:        w_br_taken = !w_lt_u;
            BR_JAL:        w_br_taken = 1'b1;
            BR_JALR, BR_JR: begin
                w_br_taken  = 1'b1;
                w_br_target = w_rs1_imm & ~{{(XLEN-1){1'b0}}, 1'b1};
            end
            default: begin
                w_br_taken  = 1'b0;
                w_br_target = '0;
            end
        endcase
    end

    // Mask is only meaningful for stores; loads and illegal sizes carry 0.
    always_comb begin
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_mask  = '0;
        if (bus.in_mem_op == MEM_STORE) begin
            case (bus.in_funct3)
                3'd0: begin w_mem_write = 1'b1; w_mem_mask = MASK_W'(8'h01); end
                3'd1: begin w_mem_write = 1'b1; w_mem_mask = MASK_W'(8'h03); end
                3'd2: begin w_mem_write = 1'b1; w_mem_mask = MASK_W'(8'h0F); end
                3'd3: begin
                    w_mem_write = (XLEN == 64);
                    w_mem_mask  = (XLEN == 64) ? MASK_W'(8'hFF) : '0;
                end
                default: ;
            endcase
        end else if (bus.in_mem_op == MEM_LOAD) begin
            case (bus.in_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_mem_read = 1'b1;
                3'd3, 3'd6:                   w_mem_read = (XLEN == 64);
                default:                      w_mem_read = 1'b0;
            endcase
        end
    end

`ifdef EXECUTE_CALC_MC_DIV_EN
    localparam int CNT_W = $clog2(XLEN);
    typedef enum logic [0:0] {S_IDLE, S_DIV_RUN} state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_div_cnt;
    logic [XLEN-1:0]  r_div_q, r_div_r, r_div_d;
    logic             r_div_is_rem;
    logic [XLEN:0]    w_rem_sh, w_diff;
    logic             w_fits;
    logic [XLEN-1:0]  w_q_next, w_r_next;
    logic             w_div_last;
    logic             w_is_div;

    assign w_is_div    = (bus.in_alu_op == ALU_DIV) || (bus.in_alu_op == ALU_REM);
    assign w_div_start = w_accept && !bus.flush && w_is_div && (w_op_b != '0);
    assign w_in_ready  = (r_state == S_IDLE);
    assign w_div_last  = (r_state == S_DIV_RUN) && (r_div_cnt == CNT_W'(XLEN-1));
    assign w_div_done  = w_div_last && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_div_start)             w_state_next = S_DIV_RUN;
            S_DIV_RUN: if (bus.flush || w_div_last) w_state_next = S_IDLE;
            default:                                w_state_next = S_IDLE;
        endcase
    end

    // Restoring step: shift the next dividend bit into the partial remainder,
    // keep the subtraction only if it did not go negative.
    assign w_rem_sh = {r_div_r, r_div_q[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div_d};
    assign w_fits   = !w_diff[XLEN];
    assign w_r_next = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_q_next = {r_div_q[XLEN-2:0], w_fits};
    assign w_div_result = r_div_is_rem ? w_r_next : w_q_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt    <= '0;
            r_div_q      <= '0;
            r_div_r      <= '0;
            r_div_d      <= '0;
            r_div_is_rem <= 1'b0;
        end else if (w_div_start) begin
            r_div_cnt    <= '0;
            r_div_q      <= w_op_a;
            r_div_r      <= '0;
            r_div_d      <= w_op_b;
            r_div_is_rem <= (bus.in_alu_op == ALU_REM);
        end else if (r_state == S_DIV_RUN) begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_div_q   <= w_q_next;
            r_div_r   <= w_r_next;
        end
    end
`else
    assign w_in_ready   = 1'b1;
    assign w_div_start  = 1'b0;
    assign w_div_done   = 1'b0;
    assign w_div_result = '0;
`endif

    // Result register. A divider completion carries no branch or memory
    // request; target/address keep their previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_br_taken  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (w_accept && !w_div_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_br_taken  <= w_br_taken;
            r_br_target <= w_br_target;
            r_mem_write <= w_mem_write;
            r_mem_read  <= w_mem_read;
            r_mem_addr  <= w_op_a + w_op_b;
            r_mem_wdata <= bus.in_rs2_val;
            r_mem_mask  <= w_mem_mask;
        end else if (w_div_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_div_result;
            r_br_taken  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_br_taken  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_alu_result = r_result;
    assign bus.branch_taken   = r_br_taken;
    assign bus.branch_target  = r_br_target;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.mem_mask       = r_mem_mask;
endmodule
